// File: rtl/cutter_pkg.sv
// cutter_pkg: definitions shared by the threshold-cutter segment store.
//   - default geometry of the BRAM segment store (words per block, pointer widths)
//   - scheduler state encoding (IDLE / STREAM / PAD / DROP)
//   - CUTTER_ADDR(blk, ptr): BRAM word address {block_no, word_ptr}. The BRAM model and the
//     PS reader build addresses with the same macro, so all three agree on the layout.
`ifndef CUTTER_PKG_SV
`define CUTTER_PKG_SV

`define CUTTER_ADDR(blk, ptr) {(blk), (ptr)}

package cutter_pkg;

    localparam int unsigned CUTTER_WINDOW_WIDTH      = 32;
    localparam int unsigned CUTTER_BLOCK_DEPTH       = 400;
    localparam int unsigned CUTTER_BLOCK_DEPTH_INDEX = 9;
    localparam int unsigned CUTTER_BLOCK_NUM_INDEX   = 6;

    typedef logic [1:0] cutter_state_t;

    localparam cutter_state_t StIdle   = 2'd0;
    localparam cutter_state_t StStream = 2'd1;
    localparam cutter_state_t StPad    = 2'd2;
    localparam cutter_state_t StDrop   = 2'd3;

endpackage

`endif

// File: rtl/block_alloc.sv
// block_alloc: round-robin block allocator for the segment store.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   close       the scheduler closes the current block this cycle
//   free        PS released the oldest used block (ignored when nothing is used)
//   block_no    block currently being filled
//   full        every block is in use
//   full_next   every block will be in use after this cycle's close/free
module block_alloc
    import cutter_pkg::*;
#(
    parameter int unsigned BLOCK_NUM_INDEX = CUTTER_BLOCK_NUM_INDEX
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       close,
    input  logic                       free,
    output logic [BLOCK_NUM_INDEX-1:0] block_no,
    output logic                       full,
    output logic                       full_next
);

    // Counter is one bit wider than block_no so "all blocks used" is representable.
    localparam logic [BLOCK_NUM_INDEX:0]   CntFull = (BLOCK_NUM_INDEX + 1)'(2 ** BLOCK_NUM_INDEX);
    localparam logic [BLOCK_NUM_INDEX:0]   CntOne  = 1;
    localparam logic [BLOCK_NUM_INDEX-1:0] BlkOne  = 1;

    logic [BLOCK_NUM_INDEX-1:0] block_no_q, block_no_d;
    logic [BLOCK_NUM_INDEX:0]   used_cnt_q, used_cnt_d;
    logic                       free_ok;

    assign free_ok = free && (used_cnt_q != '0);

    always_comb begin
        used_cnt_d = used_cnt_q;
        // A close and an accepted free in the same cycle cancel out.
        case ({close, free_ok})
            2'b10:   used_cnt_d = used_cnt_q + CntOne;
            2'b01:   used_cnt_d = used_cnt_q - CntOne;
            default: used_cnt_d = used_cnt_q;
        endcase
    end

    always_comb begin
        block_no_d = block_no_q;
        if (close) begin
            block_no_d = block_no_q + BlkOne;  // wraps naturally at 2**BLOCK_NUM_INDEX
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            block_no_q <= '0;
            used_cnt_q <= '0;
        end else begin
            block_no_q <= block_no_d;
            used_cnt_q <= used_cnt_d;
        end
    end

    assign block_no  = block_no_q;
    assign full      = (used_cnt_q == CntFull);
    assign full_next = (used_cnt_d == CntFull);

endmodule

// File: rtl/cutter_block_scheduler.sv
// cutter_block_scheduler: sequences evicted window samples into the BRAM segment store.
// An active, filled window opens a segment; each sample_valid writes one word into the
// current block, a block is closed when its last word is written, and the tail of a
// segment is zero-padded to a block boundary. With no free block the segment is dropped
// and the sticky overflow flag is raised.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   sample_valid/_data  evicted window sample (one-cycle pulse)
//   active, window_full window energy activity / window filled since last break
//   block_free          PS released the oldest used block
//   ovf_clr             clears overflow (a simultaneous set wins)
//   bram_wen/_waddr/_data  registered BRAM write port, waddr = {block_no, word_ptr}
//   block_done/_no      one-cycle pulse with the number of the block just closed
//   overflow            sticky: a segment was dropped for lack of space
//   busy                scheduler is not idle
module cutter_block_scheduler
    import cutter_pkg::*;
#(
    parameter int unsigned WINDOW_WIDTH      = CUTTER_WINDOW_WIDTH,
    parameter int unsigned BLOCK_DEPTH       = CUTTER_BLOCK_DEPTH,
    parameter int unsigned BLOCK_DEPTH_INDEX = CUTTER_BLOCK_DEPTH_INDEX,
    parameter int unsigned BLOCK_NUM_INDEX   = CUTTER_BLOCK_NUM_INDEX
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic                                     sample_valid,
    input  logic [WINDOW_WIDTH-1:0]                  sample_data,
    input  logic                                     active,
    input  logic                                     window_full,
    input  logic                                     block_free,
    input  logic                                     ovf_clr,
    output logic                                     bram_wen,
    output logic [BLOCK_NUM_INDEX+BLOCK_DEPTH_INDEX-1:0] bram_waddr,
    output logic [WINDOW_WIDTH-1:0]                  bram_data,
    output logic                                     block_done,
    output logic [BLOCK_NUM_INDEX-1:0]               block_done_no,
    output logic                                     overflow,
    output logic                                     busy
);

    localparam int unsigned AddrWidth = BLOCK_NUM_INDEX + BLOCK_DEPTH_INDEX;
    localparam logic [BLOCK_DEPTH_INDEX-1:0] PtrLast = BLOCK_DEPTH_INDEX'(BLOCK_DEPTH - 1);
    localparam logic [BLOCK_DEPTH_INDEX-1:0] PtrOne  = 1;

    cutter_state_t                state_q, state_d;
    logic [BLOCK_DEPTH_INDEX-1:0] word_ptr_q, word_ptr_d;

    logic [BLOCK_NUM_INDEX-1:0]   block_no;
    logic                         full;
    logic                         full_next;
    logic                         close;
    logic                         ovf_set;
    logic                         last_word;

    logic                         wen_d;
    logic [AddrWidth-1:0]         waddr_d;
    logic [WINDOW_WIDTH-1:0]      data_d;

    block_alloc #(
        .BLOCK_NUM_INDEX (BLOCK_NUM_INDEX)
    ) u_alloc (
        .clk       (clk),
        .rst_n     (rst_n),
        .close     (close),
        .free      (block_free),
        .block_no  (block_no),
        .full      (full),
        .full_next (full_next)
    );

    assign last_word = (word_ptr_q == PtrLast);

    always_comb begin
        state_d    = state_q;
        word_ptr_d = word_ptr_q;
        wen_d      = 1'b0;
        waddr_d    = `CUTTER_ADDR(block_no, word_ptr_q);
        data_d     = '0;
        close      = 1'b0;
        ovf_set    = 1'b0;

        case (state_q)
            StIdle: begin
                if (active && window_full) begin
                    if (full) begin
                        state_d = StDrop;
                        ovf_set = 1'b1;
                    end else begin
                        state_d    = StStream;
                        word_ptr_d = '0;
                    end
                end
            end

            StStream: begin
                if (sample_valid) begin
                    // The sample is written even if activity ended in the same cycle.
                    wen_d  = 1'b1;
                    data_d = sample_data;
                    if (last_word) begin
                        close      = 1'b1;
                        word_ptr_d = '0;
                        if (!active) begin
                            state_d = StIdle;
                        end else if (full_next) begin
                            // No block left to continue the segment into.
                            state_d = StDrop;
                            ovf_set = 1'b1;
                        end
                    end else begin
                        word_ptr_d = word_ptr_q + PtrOne;
                        if (!active) begin
                            state_d = StPad;
                        end
                    end
                end else if (!active) begin
                    // An untouched block is not consumed.
                    state_d = (word_ptr_q != '0) ? StPad : StIdle;
                end
            end

            StPad: begin
                wen_d = 1'b1;
                if (last_word) begin
                    close      = 1'b1;
                    word_ptr_d = '0;
                    state_d    = StIdle;
                end else begin
                    word_ptr_d = word_ptr_q + PtrOne;
                end
            end

            StDrop: begin
                if (!active) begin
                    state_d = StIdle;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            word_ptr_q    <= '0;
            bram_wen      <= 1'b0;
            bram_waddr    <= '0;
            bram_data     <= '0;
            block_done    <= 1'b0;
            block_done_no <= '0;
            overflow      <= 1'b0;
            busy          <= 1'b0;
        end else begin
            state_q    <= state_d;
            word_ptr_q <= word_ptr_d;
            bram_wen   <= wen_d;
            bram_waddr <= waddr_d;
            bram_data  <= data_d;
            block_done <= close;
            if (close) begin
                block_done_no <= block_no;
            end
            if (ovf_set) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
            busy <= (state_d != StIdle);
        end
    end

endmodule

// File: tb/tb_cutter_block_scheduler.sv
module tb_cutter_block_scheduler;

    localparam int WW  = 32;
    localparam int BD  = 8;
    localparam int BDI = 3;
    localparam int BNI = 6;
    localparam int NB  = 64;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 sample_valid = 1'b0;
    logic [WW-1:0]        sample_data = '0;
    logic                 active = 1'b0;
    logic                 window_full = 1'b0;
    logic                 block_free = 1'b0;
    logic                 ovf_clr = 1'b0;
    logic                 bram_wen;
    logic [BNI+BDI-1:0]   bram_waddr;
    logic [WW-1:0]        bram_data;
    logic                 block_done;
    logic [BNI-1:0]       block_done_no;
    logic                 overflow;
    logic                 busy;

    always #5 clk = ~clk;

    cutter_block_scheduler #(
        .WINDOW_WIDTH      (WW),
        .BLOCK_DEPTH       (BD),
        .BLOCK_DEPTH_INDEX (BDI),
        .BLOCK_NUM_INDEX   (BNI)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .sample_valid  (sample_valid),
        .sample_data   (sample_data),
        .active        (active),
        .window_full   (window_full),
        .block_free    (block_free),
        .ovf_clr       (ovf_clr),
        .bram_wen      (bram_wen),
        .bram_waddr    (bram_waddr),
        .bram_data     (bram_data),
        .block_done    (block_done),
        .block_done_no (block_done_no),
        .overflow      (overflow),
        .busy          (busy)
    );

    // Write and done logs, appended only by this monitor.
    logic [BNI+BDI+WW-1:0] wq[$];
    logic [BNI-1:0]        dq[$];

    always @(negedge clk) begin
        if (bram_wen) wq.push_back({bram_waddr, bram_data});
        if (block_done) dq.push_back(block_done_no);
    end

    int total = 0;
    int bad = 0;

    // Reference model: store occupancy, next block to fill, sticky overflow.
    int            m_used = 0;
    int            m_next = 0;
    bit            m_ovf = 0;
    logic [WW-1:0] samp[512];

    typedef struct {
        int n;
        bit wf;
        int frees;
        bit clr;
        int exp_w;
        int exp_d;
        int exp_first;
        bit exp_ovf;
    } row_t;

    row_t rows[8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_wen"}, 64'(bram_wen), 64'(0));
        check({tag, "_waddr"}, 64'(bram_waddr), 64'(0));
        check({tag, "_data"}, 64'(bram_data), 64'(0));
        check({tag, "_done"}, 64'(block_done), 64'(0));
        check({tag, "_done_no"}, 64'(block_done_no), 64'(0));
        check({tag, "_overflow"}, 64'(overflow), 64'(0));
        check({tag, "_busy"}, 64'(busy), 64'(0));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check_outputs_zero("reset");
        step();
        rst_n = 1'b1;
        step();
        m_used = 0;
        m_next = 0;
        m_ovf  = 0;
    endtask

    task automatic wait_idle();
        int cyc = 0;
        while (busy === 1'b1 && cyc < 64) begin
            step();
            cyc++;
        end
        check("busy_release", 64'(busy), 64'(0));
        repeat (2) step();
    endtask

    // Expected segment outcome from the storage rules: samples fill consecutive blocks,
    // the tail is zero-padded, and the segment is cut off once every block is used.
    task automatic verify_segment(input int w0, input int d0, input int n, input bit wf,
                                  output int nw, output int nd);
        int            avail;
        int            written;
        int            blocks;
        logic [BNI-1:0] b;
        logic [BDI-1:0] w;
        logic [WW-1:0]  d;
        nw = wq.size() - w0;
        nd = dq.size() - d0;
        written = 0;
        blocks  = 0;
        if (wf) begin
            avail   = NB - m_used;
            written = (n < avail * BD) ? n : avail * BD;
            blocks  = (written + BD - 1) / BD;
            if (n >= avail * BD) m_ovf = 1;
        end
        check("seg_writes", 64'(nw), 64'(blocks * BD));
        check("seg_dones", 64'(nd), 64'(blocks));
        for (int i = 0; i < blocks * BD && i < nw; i++) begin
            b = BNI'((m_next + i / BD) % NB);
            w = BDI'(i % BD);
            d = (i < written) ? samp[i] : '0;
            check("seg_word", 64'(wq[w0+i]), 64'({b, w, d}));
        end
        for (int j = 0; j < blocks && j < nd; j++) begin
            check("seg_done_no", 64'(dq[d0+j]), 64'((m_next + j) % NB));
        end
        m_used += blocks;
        m_next  = (m_next + blocks) % NB;
        check("seg_overflow", 64'(overflow), 64'(m_ovf));
    endtask

    task automatic run_segment(input int n, input bit wf, input int frees, input bit clr,
                               output int nw, output int nd);
        int w0;
        int d0;
        int gap;
        for (int i = 0; i < frees; i++) begin
            block_free = 1'b1;
            step();
            block_free = 1'b0;
            if (m_used > 0) m_used--;
        end
        if (clr) begin
            ovf_clr = 1'b1;
            step();
            ovf_clr = 1'b0;
            m_ovf = 0;
        end
        step();
        w0 = wq.size();
        d0 = dq.size();
        active = 1'b1;
        window_full = wf;
        step();
        for (int i = 0; i < n; i++) begin
            samp[i] = $urandom;
            sample_valid = 1'b1;
            sample_data = samp[i];
            step();
            sample_valid = 1'b0;
            gap = $urandom_range(0, 2);
            repeat (gap) step();
        end
        active = 1'b0;
        window_full = 1'b0;
        wait_idle();
        verify_segment(w0, d0, n, wf, nw, nd);
    endtask

    initial begin
        int nw;
        int nd;
        int d0;
        int n;

        rows[0] = '{5,   1, 0, 0, 8,   1,  0, 0};
        rows[1] = '{20,  1, 0, 0, 24,  3,  1, 0};
        rows[2] = '{4,   0, 0, 0, 0,   0,  0, 0};
        rows[3] = '{0,   1, 0, 0, 0,   0,  0, 0};
        rows[4] = '{479, 1, 0, 0, 480, 60, 4, 0};
        rows[5] = '{3,   1, 0, 0, 0,   0,  0, 1};
        rows[6] = '{2,   1, 1, 0, 8,   1,  0, 1};
        rows[7] = '{0,   0, 0, 1, 0,   0,  0, 0};

        #12;
        check_outputs_zero("init");
        do_reset();

        for (int r = 0; r < 8; r++) begin
            d0 = dq.size();
            run_segment(rows[r].n, rows[r].wf, rows[r].frees, rows[r].clr, nw, nd);
            check("row_writes", 64'(nw), 64'(rows[r].exp_w));
            check("row_dones", 64'(nd), 64'(rows[r].exp_d));
            if (rows[r].exp_d > 0 && nd > 0)
                check("row_first_no", 64'(dq[d0]), 64'(rows[r].exp_first));
            check("row_overflow", 64'(overflow), 64'(rows[r].exp_ovf));
        end

        // Free with nothing used is ignored.
        do_reset();
        block_free = 1'b1;
        step();
        block_free = 1'b0;
        step();
        check("free_at_zero", 64'(dut.u_alloc.used_cnt_q), 64'(0));

        // Free coincident with a closing write leaves occupancy unchanged.
        run_segment(5, 1'b1, 0, 1'b0, nw, nd);
        d0 = dq.size();
        active = 1'b1;
        window_full = 1'b1;
        step();
        for (int i = 0; i < BD; i++) begin
            sample_valid = 1'b1;
            sample_data = WW'(i + 100);
            block_free = (i == BD - 1);
            step();
        end
        sample_valid = 1'b0;
        block_free = 1'b0;
        active = 1'b0;
        window_full = 1'b0;
        wait_idle();
        check("free_close_used", 64'(dut.u_alloc.used_cnt_q), 64'(1));
        check("free_close_dones", 64'(dq.size() - d0), 64'(1));
        if (dq.size() > d0) check("free_close_no", 64'(dq[d0]), 64'(1));

        // Asynchronous reset in the middle of padding.
        do_reset();
        active = 1'b1;
        window_full = 1'b1;
        step();
        for (int i = 0; i < 3; i++) begin
            sample_valid = 1'b1;
            sample_data = WW'(i + 7);
            step();
        end
        sample_valid = 1'b0;
        active = 1'b0;
        window_full = 1'b0;
        step();
        step();
        check("pad_wen_before_reset", 64'(bram_wen), 64'(1));
        #2;
        rst_n = 1'b0;
        #1;
        check_outputs_zero("async_reset");
        step();
        rst_n = 1'b1;
        m_used = 0;
        m_next = 0;
        m_ovf  = 0;
        step();
        run_segment(2, 1'b1, 0, 1'b0, nw, nd);

        // Randomized segments against the model, long enough to fill the store.
        do_reset();
        for (int s = 0; s < 40; s++) begin
            n = $urandom_range(0, 40);
            run_segment(n, ($urandom_range(0, 7) != 0), $urandom_range(0, 2),
                        ($urandom_range(0, 5) == 0), nw, nd);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
